move_cmd_encoder: RTL and testbench

//   Front end between the five raw board buttons and the TwentyFortyEight game core.

---
 rtl/move_cmd_encoder.sv | 134 +++++++++++++
 tb/tb_move_cmd_encoder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_cmd_encoder.sv
// move_cmd_encoder
//   Front end between the five raw board buttons and the game core. Each raw
//   button is passed through a 2-FF synchroniser, the synced vector is
//   debounced with one shared counter, and a fresh debounced press is encoded
//   into a 3-bit move command delivered over a valid/ready handshake. Holding
//   a button yields one command; all buttons must be released before re-arm.
// Ports
//   clk        system clock, posedge
//   rst        asynchronous active-low reset
//   btnu/btnd/btnl/btnr/btns  raw buttons, asynchronous to clk
//   cmd_valid  command pending
//   cmd_dir    0=up 1=down 2=left 3=right 4=select; 4 when idle
//   cmd_ready  core accepts on cmd_valid && cmd_ready
//   drop_cnt   saturating count of presses discarded while a command pended
module move_cmd_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btnu,
  input  logic       btnd,
  input  logic       btnl,
  input  logic       btnr,
  input  logic       btns,
  output logic       cmd_valid,
  output logic [2:0] cmd_dir,
  input  logic       cmd_ready,
  output logic [7:0] drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PEND,
    WAIT_REL
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       DIR_IDLE = 3'd4;

  state_t          state;
  logic [4:0]      raw;
  logic [4:0]      s1;
  logic [4:0]      s;
  logic [4:0]      s_prev;
  logic [4:0]      db;
  logic [4:0]      db_prev;
  logic [4:0]      rise;
  logic [CNT_W-1:0] cnt;
  logic [2:0]      enc_dir;

  // Bit order {btns,btnu,btnd,btnl,btnr}.
  assign raw  = {btns, btnu, btnd, btnl, btnr};
  assign rise = db & ~db_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= '0;
      s      <= '0;
      s_prev <= '0;
    end else begin
      s1     <= raw;
      s      <= s1;
      s_prev <= s;
    end
  end

  // Any change of the synced vector restarts the stability window, so db only
  // follows a vector that has held still for DEBOUNCE_CYCLES cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db      <= '0;
      db_prev <= '0;
      cnt     <= '0;
    end else begin
      db_prev <= db;
      if (s == db || s != s_prev) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Priority: select > up > down > left > right.
  always_comb begin
    enc_dir = DIR_IDLE;
    if (rise[4])      enc_dir = 3'd4;
    else if (rise[3]) enc_dir = 3'd0;
    else if (rise[2]) enc_dir = 3'd1;
    else if (rise[1]) enc_dir = 3'd2;
    else if (rise[0]) enc_dir = 3'd3;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cmd_valid <= 1'b0;
      cmd_dir   <= DIR_IDLE;
      drop_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|rise) begin
            cmd_dir   <= enc_dir;
            cmd_valid <= 1'b1;
            state     <= PEND;
          end
        end
        PEND: begin
          // A rise coinciding with an accept is still counted as dropped.
          if (|rise && drop_cnt != 8'hff) begin
            drop_cnt <= drop_cnt + 8'd1;
          end
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            cmd_dir   <= DIR_IDLE;
            state     <= WAIT_REL;
          end
        end
        WAIT_REL: begin
          if (db == '0) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_move_cmd_encoder.sv
module tb_move_cmd_encoder;

  localparam int D = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] b;          // {btns,btnu,btnd,btnl,btnr}
  logic       ready;
  logic       cmd_valid;
  logic [2:0] cmd_dir;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;

  move_cmd_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(5)) dut (
    .clk      (clk),
    .rst      (rst),
    .btnu     (b[3]),
    .btnd     (b[2]),
    .btnl     (b[1]),
    .btnr     (b[0]),
    .btns     (b[4]),
    .cmd_valid(cmd_valid),
    .cmd_dir  (cmd_dir),
    .cmd_ready(ready),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  // Observation: accepted commands, valid-high cycles, protocol violations.
  logic [2:0] acc_q[$];
  int         valid_cycles = 0;
  int         hold_err = 0;
  int         idle_err = 0;
  logic       prev_valid = 1'b0;
  logic       prev_acc = 1'b0;
  logic [2:0] prev_dir = 3'd4;

  always @(negedge clk) begin
    if (cmd_valid === 1'b1) begin
      valid_cycles++;
      if (ready) acc_q.push_back(cmd_dir);
      if (prev_valid && !prev_acc && cmd_dir !== prev_dir) hold_err++;
    end else if (cmd_dir !== 3'd4) begin
      idle_err++;
    end
    prev_valid = (cmd_valid === 1'b1);
    prev_acc   = (cmd_valid === 1'b1) && ready;
    prev_dir   = cmd_dir;
  end

  // Reference model: expected command stream and drop count.
  logic [2:0] exp_q[$];
  int         exp_drop = 0;

  function automatic logic [2:0] model_dir(input logic [4:0] mask);
    int unsigned order[5] = '{4, 3, 2, 1, 0};   // select, up, down, left, right
    logic [2:0]  dirs[5]  = '{3'd4, 3'd0, 3'd1, 3'd2, 3'd3};
    for (int i = 0; i < 5; i++)
      if (mask[order[i]]) return dirs[i];
    return 3'd4;
  endfunction

  function automatic int sat_add(input int a, input int n);
    return (a + n > 255) ? 255 : a + n;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input logic [4:0] mask, input int hold);
    b = mask;
    tick(hold);
    b = '0;
    tick(D + 12);
  endtask

  task automatic expect_cmds(input string tag);
    check({tag, ".count"}, acc_q.size(), exp_q.size());
    while (acc_q.size() > 0 && exp_q.size() > 0)
      check({tag, ".dir"}, {29'd0, acc_q.pop_front()}, {29'd0, exp_q.pop_front()});
    acc_q.delete();
    exp_q.delete();
    check({tag, ".drop"}, {24'd0, drop_cnt}, exp_drop);
  endtask

  int v0;

  initial begin
    rst = 1'b0; b = '0; ready = 1'b0;
    tick(3);
    check("reset.valid", {31'd0, cmd_valid}, 0);
    check("reset.dir", {29'd0, cmd_dir}, 4);
    check("reset.drop", {24'd0, drop_cnt}, 0);
    rst = 1'b1;
    tick(2);

    // btnd held 30 cycles, ready high
    ready = 1'b1;
    press(5'b00100, 30);
    exp_q.push_back(model_dir(5'b00100));
    tick(20);
    expect_cmds("down");

    // short btnl glitch never reaches the core
    v0 = valid_cycles;
    b = 5'b00010; tick(10); b = '0;
    tick(200);
    check("glitch.valid", valid_cycles, v0);

    // pending command held while further presses are dropped
    ready = 1'b0;
    press(5'b01000, 30);
    b = 5'b00001;
    tick(30);
    check("pend.valid", {31'd0, cmd_valid}, 1);
    check("pend.dir", {29'd0, cmd_dir}, 0);
    exp_drop = sat_add(exp_drop, 1);
    check("pend.drop", {24'd0, drop_cnt}, exp_drop);
    ready = 1'b1;
    tick(2);
    b = '0;
    tick(D + 40);
    exp_q.push_back(3'd0);
    expect_cmds("pend");

    // simultaneous up+left
    press(5'b01010, 30);
    exp_q.push_back(model_dir(5'b01010));
    tick(20);
    expect_cmds("simul");

    // long select hold: one command, re-arm only after release
    b = 5'b10000;
    tick(500);
    exp_q.push_back(3'd4);
    expect_cmds("hold");
    b = '0;
    tick(D + 20);
    expect_cmds("hold.rel");
    press(5'b01000, 30);
    exp_q.push_back(3'd0);
    tick(20);
    expect_cmds("rearm");

    // async reset while pending
    ready = 1'b0;
    b = 5'b00100;
    tick(30);
    check("prst.valid", {31'd0, cmd_valid}, 1);
    #1 rst = 1'b0;
    #1;
    check("arst.valid", {31'd0, cmd_valid}, 0);
    check("arst.dir", {29'd0, cmd_dir}, 4);
    check("arst.drop", {24'd0, drop_cnt}, 0);
    exp_drop = 0;
    b = '0;
    tick(5);
    rst = 1'b1;
    v0 = valid_cycles;
    tick(100);
    check("postrst.valid", valid_cycles, v0);
    acc_q.delete();
    ready = 1'b1;
    press(5'b00100, 30);
    exp_q.push_back(3'd1);
    tick(20);
    expect_cmds("postrst");

    // randomized episodes
    for (int ep = 0; ep < 24; ep++) begin
      int unsigned mode = $urandom_range(0, 2);
      if (mode == 0) begin
        logic [4:0] m = 5'($urandom_range(1, 31));
        ready = 1'($urandom_range(0, 1));
        press(m, $urandom_range(D + 8, D + 40));
        exp_q.push_back(model_dir(m));
        ready = 1'b1;
        tick(D + 20);
        expect_cmds("rand.single");
      end else if (mode == 1) begin
        int unsigned k = $urandom_range(1, 3);
        ready = 1'b0;
        for (int unsigned j = 0; j < k; j++) begin
          logic [4:0] m = 5'($urandom_range(1, 31));
          if (j == 0) exp_q.push_back(model_dir(m));
          press(m, $urandom_range(D + 8, D + 30));
        end
        exp_drop = sat_add(exp_drop, int'(k) - 1);
        ready = 1'b1;
        tick(D + 20);
        expect_cmds("rand.multi");
      end else begin
        ready = 1'b1;
        v0 = valid_cycles;
        b = 5'($urandom_range(1, 31));
        tick($urandom_range(1, D - 3));
        b = '0;
        tick(40);
        check("rand.glitch", valid_cycles, v0);
      end
    end

    // drop counter saturation
    ready = 1'b0;
    for (int j = 0; j < 262; j++) begin
      logic [4:0] m = 5'($urandom_range(1, 31));
      if (j == 0) exp_q.push_back(model_dir(m));
      press(m, D + 6);
    end
    exp_drop = sat_add(exp_drop, 261);
    check("sat.drop", {24'd0, drop_cnt}, exp_drop);
    ready = 1'b1;
    tick(D + 20);
    expect_cmds("sat");

    check("proto.hold", hold_err, 0);
    check("proto.idle_dir", idle_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
